// File: rtl/cache_tag_pkg.sv
// Shared types and constants for the fully-associative cache tag store.
package cache_tag_pkg;

  localparam int unsigned REPL_FIFO = 0;
  localparam int unsigned REPL_LRU  = 1;

  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} flush_state_e;

endpackage

// File: rtl/cache_tag_lru.sv
// True-LRU age tracker: ages form a permutation of 0..DP-1, oldest entry is the victim.
module cache_tag_lru #(
  parameter int unsigned DP = 8,
  localparam int unsigned IDX_W = $clog2(DP)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic             clear,
  output logic [IDX_W-1:0] vic_idx
);

  logic [IDX_W-1:0] age_q [DP];
  logic [IDX_W-1:0] age_d [DP];

  // Touched entry becomes youngest; only entries younger than it age by one.
  always_comb begin
    for (int i = 0; i < DP; i++) age_d[i] = age_q[i];
    if (clear) begin
      for (int i = 0; i < DP; i++) age_d[i] = IDX_W'(i);
    end else if (touch_en) begin
      for (int i = 0; i < DP; i++) begin
        if (IDX_W'(i) == touch_idx) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[touch_idx]) begin
          age_d[i] = age_q[i] + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DP; i++) age_q[i] <= IDX_W'(i);
    end else begin
      for (int i = 0; i < DP; i++) age_q[i] <= age_d[i];
    end
  end

  always_comb begin
    vic_idx = '0;
    for (int i = 0; i < DP; i++) begin
      if (age_q[i] == IDX_W'(DP - 1)) vic_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cache_tag_store.sv
// Fully-associative tag store with dirty bits, FIFO/LRU replacement and a
// sequential flush engine that hands dirty tags out for writeback.
module cache_tag_store
  import cache_tag_pkg::*;
#(
  parameter int unsigned TAG_W = 20,
  parameter int unsigned DP    = 8,
  parameter int unsigned REPL  = 1,
  parameter int unsigned WB_EN = 1,
  localparam int unsigned IDX_W = $clog2(DP),
  localparam int unsigned CNT_W = $clog2(DP + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [TAG_W-1:0] lk_tag,
  output logic [DP-1:0]    lk_hit,
  output logic [DP-1:0]    lk_next_hit,
  output logic [IDX_W-1:0] lk_hidx,
  output logic             lk_any,
  input  logic             touch,
  output logic [IDX_W-1:0] vic_idx,
  output logic             vic_valid,
  output logic             vic_dirty,
  output logic [TAG_W-1:0] vic_tag,
  input  logic             alloc,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             alloc_dirty,
  input  logic             upd,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             inv,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic             flush_req,
  output logic             busy,
  output logic             flush_done,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [IDX_W-1:0] wb_idx,
  output logic [TAG_W-1:0] wb_tag,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } cache_tag_ent_s;

  cache_tag_ent_s   ent_q [DP];
  cache_tag_ent_s   ent_d [DP];
  flush_state_e     state_q, state_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] inv_first, lru_vic;
  logic [DP-1:0]    hit_raw, next_raw;
  logic [TAG_W-1:0] next_tag;
  logic [CNT_W-1:0] cnt;
  logic             busy_int, any_inv, do_alloc, do_upd, clear_cur, flush_last;

  assign busy_int   = (state_q == SCAN) || (state_q == WB);
  assign busy       = busy_int;
  assign flush_done = (state_q == DONE);
  assign wb_valid   = (state_q == WB);
  assign wb_idx     = fidx_q;
  assign wb_tag     = ent_q[fidx_q].tag;

  // Lookup
  assign next_tag = lk_tag + TAG_W'(1);

  always_comb begin
    for (int i = 0; i < DP; i++) begin
      hit_raw[i]  = ent_q[i].valid && (ent_q[i].tag == lk_tag);
      next_raw[i] = ent_q[i].valid && (ent_q[i].tag == next_tag);
    end
  end

  assign lk_hit      = busy_int ? '0 : hit_raw;
  assign lk_next_hit = busy_int ? '0 : next_raw;
  assign lk_any      = |lk_hit;

  always_comb begin
    lk_hidx = '0;
    for (int i = int'(DP) - 1; i >= 0; i--) begin
      if (lk_hit[i]) lk_hidx = IDX_W'(i);
    end
  end

  // Victim: lowest invalid entry first, policy only once the store is full
  always_comb begin
    any_inv   = 1'b0;
    inv_first = '0;
    for (int i = int'(DP) - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        any_inv   = 1'b1;
        inv_first = IDX_W'(i);
      end
    end
  end

  assign vic_idx   = any_inv ? inv_first : ((REPL == REPL_LRU) ? lru_vic : ptr_q);
  assign vic_valid = ent_q[vic_idx].valid;
  assign vic_dirty = ent_q[vic_idx].dirty;
  assign vic_tag   = ent_q[vic_idx].tag;

  // Occupancy
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DP; i++) cnt = cnt + CNT_W'(ent_q[i].valid);
  end

  assign count = cnt;
  assign full  = (cnt == CNT_W'(DP));
  assign empty = (cnt == '0);

  assign do_alloc = !busy_int && alloc && !inv;
  assign do_upd   = !busy_int && upd && !inv && !alloc && ent_q[upd_idx].valid;

  always_comb begin
    for (int i = 0; i < DP; i++) ent_d[i] = ent_q[i];
    state_d    = state_q;
    fidx_d     = fidx_q;
    ptr_d      = ptr_q;
    clear_cur  = 1'b0;
    flush_last = 1'b0;

    if (!busy_int) begin
      if (inv) begin
        ent_d[inv_idx].valid = 1'b0;
        ent_d[inv_idx].dirty = 1'b0;
      end else if (do_alloc) begin
        ent_d[vic_idx] = {1'b1, alloc_dirty, alloc_tag};
        if (!any_inv) ptr_d = ptr_q + IDX_W'(1);
      end else if (do_upd) begin
        ent_d[upd_idx].dirty = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = SCAN;
          fidx_d  = '0;
        end
      end
      SCAN: begin
        if ((WB_EN != 0) && ent_q[fidx_q].valid && ent_q[fidx_q].dirty) state_d = WB;
        else clear_cur = 1'b1;
      end
      WB: begin
        if (wb_ready) begin
          clear_cur = 1'b1;
          state_d   = SCAN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear_cur) begin
      ent_d[fidx_q] = '0;
      if (fidx_q == IDX_W'(DP - 1)) begin
        state_d    = DONE;
        flush_last = 1'b1;
        ptr_d      = '0;
      end else begin
        fidx_d = fidx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fidx_q  <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < DP; i++) ent_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < DP; i++) ent_q[i] <= ent_d[i];
    end
  end

  if (REPL == REPL_LRU) begin : g_lru
    logic             touch_en;
    logic [IDX_W-1:0] touch_idx;

    // Only the highest-priority touch source of the cycle ages the table
    assign touch_en  = do_alloc || do_upd || (touch && lk_any);
    assign touch_idx = do_alloc ? vic_idx : (do_upd ? upd_idx : lk_hidx);

    cache_tag_lru #(
      .DP(DP)
    ) u_lru (
      .clk      (clk),
      .reset_n  (reset_n),
      .touch_en (touch_en),
      .touch_idx(touch_idx),
      .clear    (flush_last),
      .vic_idx  (lru_vic)
    );
  end else begin : g_fifo
    assign lru_vic = '0;
  end

endmodule

// File: tb/tb_cache_tag_store.sv
// Bench for cache_tag_store: an LRU and a FIFO instance, driven one at a time,
// each checked against a queue/array model of the tag store.
module tb_cache_tag_store;

  localparam int unsigned TAG_W = 20;
  localparam int unsigned DP    = 8;
  localparam int unsigned IDX_W = $clog2(DP);
  localparam int unsigned CNT_W = $clog2(DP + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             sel;  // 1: LRU instance active, 0: FIFO instance active
  logic [TAG_W-1:0] lk_tag, alloc_tag;
  logic             touch, alloc, alloc_dirty, upd, inv, flush_req, wb_ready;
  logic [IDX_W-1:0] upd_idx, inv_idx;

  logic [DP-1:0]    l_hit, l_nhit, f_hit, f_nhit, o_hit, o_nhit;
  logic [IDX_W-1:0] l_hidx, f_hidx, o_hidx, l_vidx, f_vidx, o_vidx, l_wbi, f_wbi, o_wbi;
  logic [TAG_W-1:0] l_vtag, f_vtag, o_vtag, l_wbt, f_wbt, o_wbt;
  logic [CNT_W-1:0] l_cnt, f_cnt, o_cnt;
  logic l_any, f_any, o_any, l_vv, f_vv, o_vv, l_vd, f_vd, o_vd, l_busy, f_busy, o_busy;
  logic l_done, f_done, o_done, l_wbv, f_wbv, o_wbv, l_full, f_full, o_full;
  logic l_empty, f_empty, o_empty;

  cache_tag_store #(.TAG_W(TAG_W), .DP(DP), .REPL(1), .WB_EN(1)) u_dut_lru (
    .clk(clk), .reset_n(reset_n), .lk_tag(lk_tag), .lk_hit(l_hit), .lk_next_hit(l_nhit),
    .lk_hidx(l_hidx), .lk_any(l_any), .touch(touch & sel), .vic_idx(l_vidx),
    .vic_valid(l_vv), .vic_dirty(l_vd), .vic_tag(l_vtag), .alloc(alloc & sel),
    .alloc_tag(alloc_tag), .alloc_dirty(alloc_dirty), .upd(upd & sel), .upd_idx(upd_idx),
    .inv(inv & sel), .inv_idx(inv_idx), .flush_req(flush_req & sel), .busy(l_busy),
    .flush_done(l_done), .wb_valid(l_wbv), .wb_ready(wb_ready & sel), .wb_idx(l_wbi),
    .wb_tag(l_wbt), .count(l_cnt), .full(l_full), .empty(l_empty)
  );

  cache_tag_store #(.TAG_W(TAG_W), .DP(DP), .REPL(0), .WB_EN(1)) u_dut_fifo (
    .clk(clk), .reset_n(reset_n), .lk_tag(lk_tag), .lk_hit(f_hit), .lk_next_hit(f_nhit),
    .lk_hidx(f_hidx), .lk_any(f_any), .touch(touch & ~sel), .vic_idx(f_vidx),
    .vic_valid(f_vv), .vic_dirty(f_vd), .vic_tag(f_vtag), .alloc(alloc & ~sel),
    .alloc_tag(alloc_tag), .alloc_dirty(alloc_dirty), .upd(upd & ~sel), .upd_idx(upd_idx),
    .inv(inv & ~sel), .inv_idx(inv_idx), .flush_req(flush_req & ~sel), .busy(f_busy),
    .flush_done(f_done), .wb_valid(f_wbv), .wb_ready(wb_ready & ~sel), .wb_idx(f_wbi),
    .wb_tag(f_wbt), .count(f_cnt), .full(f_full), .empty(f_empty)
  );

  assign o_hit   = sel ? l_hit   : f_hit;
  assign o_nhit  = sel ? l_nhit  : f_nhit;
  assign o_hidx  = sel ? l_hidx  : f_hidx;
  assign o_any   = sel ? l_any   : f_any;
  assign o_vidx  = sel ? l_vidx  : f_vidx;
  assign o_vv    = sel ? l_vv    : f_vv;
  assign o_vd    = sel ? l_vd    : f_vd;
  assign o_vtag  = sel ? l_vtag  : f_vtag;
  assign o_busy  = sel ? l_busy  : f_busy;
  assign o_done  = sel ? l_done  : f_done;
  assign o_wbv   = sel ? l_wbv   : f_wbv;
  assign o_wbi   = sel ? l_wbi   : f_wbi;
  assign o_wbt   = sel ? l_wbt   : f_wbt;
  assign o_cnt   = sel ? l_cnt   : f_cnt;
  assign o_full  = sel ? l_full  : f_full;
  assign o_empty = sel ? l_empty : f_empty;

  // Reference model: plain arrays plus a recency queue (front = most recently used)
  bit               m_valid [DP];
  bit               m_dirty [DP];
  logic [TAG_W-1:0] m_tag   [DP];
  int               m_order [$];
  int               m_ptr;

  int n_cmp, n_bad;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%s] t=%0t: got 0x%0h, want 0x%0h", name, sel ? "lru" : "fifo",
               $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_order.delete();
    for (int i = 0; i < DP; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = '0;
      m_order.push_back(i);
    end
    m_ptr = 0;
  endtask

  function automatic int m_victim();
    for (int i = 0; i < DP; i++) if (!m_valid[i]) return i;
    if (sel) return m_order[m_order.size() - 1];
    return m_ptr;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DP; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  function automatic int m_first_hit();
    for (int i = 0; i < DP; i++) if (m_valid[i] && m_tag[i] == lk_tag) return i;
    return -1;
  endfunction

  task automatic m_touch(input int k);
    for (int j = 0; j < m_order.size(); j++) begin
      if (m_order[j] == k) begin
        m_order.delete(j);
        break;
      end
    end
    m_order.push_front(k);
  endtask

  task automatic check_all();
    logic [DP-1:0]    eh, en;
    logic [TAG_W-1:0] nt;
    int h, v, c;
    eh = '0;
    en = '0;
    nt = lk_tag + 1'b1;
    for (int i = 0; i < DP; i++) begin
      eh[i] = m_valid[i] && (m_tag[i] == lk_tag);
      en[i] = m_valid[i] && (m_tag[i] == nt);
    end
    h = m_first_hit();
    v = m_victim();
    c = m_count();
    check_eq("lk_hit", o_hit, eh);
    check_eq("lk_next_hit", o_nhit, en);
    check_eq("lk_hidx", o_hidx, (h < 0) ? 0 : h);
    check_eq("lk_any", o_any, h >= 0);
    check_eq("vic_idx", o_vidx, v);
    check_eq("vic_valid", o_vv, m_valid[v]);
    if (m_valid[v]) begin
      check_eq("vic_dirty", o_vd, m_dirty[v]);
      check_eq("vic_tag", o_vtag, m_tag[v]);
    end
    check_eq("count", o_cnt, c);
    check_eq("full", o_full, c == DP);
    check_eq("empty", o_empty, c == 0);
    check_eq("busy_idle", o_busy, 0);
    check_eq("wb_valid_idle", o_wbv, 0);
    check_eq("flush_done_idle", o_done, 0);
  endtask

  task automatic model_update();
    int v, h;
    bit a, u;
    h = m_first_hit();
    v = m_victim();
    a = alloc && !inv;
    u = upd && !inv && !alloc && m_valid[upd_idx];
    if (inv) begin
      m_valid[inv_idx] = 0;
      m_dirty[inv_idx] = 0;
    end else if (a) begin
      if (m_valid[v]) m_ptr = (m_ptr + 1) % DP;
      m_valid[v] = 1;
      m_dirty[v] = alloc_dirty;
      m_tag[v]   = alloc_tag;
    end else if (u) begin
      m_dirty[upd_idx] = 1;
    end
    if (a) m_touch(v);
    else if (u) m_touch(upd_idx);
    else if (touch && h >= 0) m_touch(h);
  endtask

  task automatic clear_ops();
    touch = 0; alloc = 0; upd = 0; inv = 0; flush_req = 0; alloc_dirty = 0;
  endtask

  // One cycle: check outputs and advance the model before the edge, then release ops
  task automatic step();
    @(negedge clk);
    check_all();
    model_update();
    @(posedge clk);
    #1;
    clear_ops();
  endtask

  task automatic apply_reset();
    clear_ops();
    wb_ready = 0;
    reset_n  = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [TAG_W-1:0] t, input logic d);
    alloc = 1; alloc_tag = t; alloc_dirty = d;
    step();
  endtask

  task automatic flush_run(input int wait_n);
    int dl [$];
    int k, cnt, busy_cyc, exp_cyc;
    bit done_seen;
    for (int i = 0; i < DP; i++) if (m_valid[i] && m_dirty[i]) dl.push_back(i);
    exp_cyc = DP + dl.size() * (wait_n + 1);
    flush_req = 1;
    step();
    k = 0; cnt = 0; busy_cyc = 0; done_seen = 0;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      @(negedge clk);
      if (o_busy) begin
        busy_cyc++;
        check_eq("busy_lk_any", o_any, 0);
        check_eq("busy_lk_hit", o_hit, 0);
        if (o_wbv) begin
          cnt++;
          if (k < dl.size()) begin
            check_eq("wb_idx", o_wbi, dl[k]);
            check_eq("wb_tag", o_wbt, m_tag[dl[k]]);
          end else begin
            check_eq("wb_extra", o_wbv, 0);
          end
          wb_ready = (cnt > wait_n);
          if (wb_ready) begin
            k++;
            cnt = 0;
          end
        end else begin
          wb_ready = 0;
        end
      end else begin
        done_seen = 1;
        wb_ready  = 0;
        check_eq("flush_done", o_done, 1);
        check_eq("flush_wb_valid", o_wbv, 0);
        check_eq("flush_count", o_cnt, 0);
        check_eq("flush_empty", o_empty, 1);
        check_eq("flush_cycles", busy_cyc, exp_cyc);
        check_eq("wb_requests", k, dl.size());
      end
    end
    wb_ready = 0;
    if (!done_seen) check_eq("flush_timeout", o_busy, 0);
    model_reset();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TAG_W-1:0] rand_tag();
    int r = $urandom_range(0, 17);
    if (r == 16) return '1;
    if (r == 17) return '0;
    return TAG_W'(32'h10 + r);
  endfunction

  task automatic run_directed();
    bit got;
    check_eq("rst_count", o_cnt, 0);
    check_eq("rst_empty", o_empty, 1);
    check_eq("rst_full", o_full, 0);
    check_eq("rst_busy", o_busy, 0);
    for (int i = 0; i < DP; i++) begin
      check_eq("fill_vic", o_vidx, i);
      do_alloc(TAG_W'(32'h10 + i), 0);
    end
    check_eq("fill_count", o_cnt, 8);
    check_eq("fill_full", o_full, 1);
    lk_tag = 20'h13;
    #1;
    check_eq("lk13_hit", o_hit, 8'h08);
    check_eq("lk13_hidx", o_hidx, 3);
    check_eq("lk13_next", o_nhit, 8'h10);
    if (sel) begin
      lk_tag = 20'h10; touch = 1;
      step();
      check_eq("lru_vic", o_vidx, 1);
      check_eq("lru_vic_valid", o_vv, 1);
      do_alloc(20'h20, 0);
      check_eq("lru_count", o_cnt, 8);
      lk_tag = 20'h20;
      #1;
      check_eq("lru_alloc_hit", o_hit, 8'h02);
    end else begin
      for (int j = 0; j < 3; j++) begin
        check_eq("fifo_vic", o_vidx, j);
        do_alloc(TAG_W'(32'h30 + j), 0);
      end
      inv = 1; inv_idx = 5;
      step();
      check_eq("fifo_inv_count", o_cnt, 7);
      check_eq("fifo_vic_inv", o_vidx, 5);
      do_alloc(20'h40, 0);
      check_eq("fifo_ptr_kept", o_vidx, 3);
      lk_tag = 20'h40;
      #1;
      check_eq("fifo_alloc_hit", o_hit, 8'h20);
    end
    // inv beats alloc, alloc beats upd
    inv = 1; inv_idx = 2; alloc = 1; alloc_tag = 20'h55;
    step();
    check_eq("inv_wins_count", o_cnt, 7);
    lk_tag = 20'h55;
    #1;
    check_eq("inv_wins_nohit", o_any, 0);
    alloc = 1; alloc_tag = 20'h66; upd = 1; upd_idx = 4;
    step();
    lk_tag = 20'h66;
    #1;
    check_eq("alloc_wins_hit", o_hit, 8'h04);
    flush_run(0);
    // Dirty entries 1 and 6, slow writeback acceptor
    for (int i = 0; i < DP; i++) do_alloc(TAG_W'(32'h70 + i), 0);
    upd = 1; upd_idx = 1;
    step();
    upd = 1; upd_idx = 6;
    step();
    lk_tag = 20'h71;
    flush_run(3);
    // Reset asserted while waiting in writeback
    do_alloc(20'h90, 1);
    flush_req = 1;
    step();
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = o_wbv;
    end
    check_eq("rst_wb_seen", o_wbv, 1);
    #2 reset_n = 0;
    #1;
    check_eq("arst_busy", o_busy, 0);
    check_eq("arst_wb_valid", o_wbv, 0);
    check_eq("arst_count", o_cnt, 0);
    check_eq("arst_vic_valid", o_vv, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_random();
    for (int n = 0; n < 300; n++) begin
      lk_tag      = rand_tag();
      alloc       = ($urandom_range(0, 99) < 40);
      alloc_tag   = rand_tag();
      alloc_dirty = $urandom_range(0, 1);
      upd         = ($urandom_range(0, 99) < 25);
      upd_idx     = IDX_W'($urandom_range(0, DP - 1));
      inv         = ($urandom_range(0, 99) < 12);
      inv_idx     = IDX_W'($urandom_range(0, DP - 1));
      touch       = ($urandom_range(0, 99) < 35);
      step();
      if (n % 100 == 99) flush_run(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sel = 1;
    lk_tag = '0; alloc_tag = '0; upd_idx = '0; inv_idx = '0; wb_ready = 0;
    clear_ops();
    for (int s = 1; s >= 0; s--) begin
      sel = (s == 1);
      apply_reset();
      run_directed();
      run_random();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
